// File: rtl/pipeline_flow_controller_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush sequencer.
// master: the flow controller (consumes hazard inputs, drives stage controls).
// slave:  the pipeline datapath (drives hazard inputs, consumes stage controls).
interface pipeline_flow_controller_if #(
  parameter int unsigned CNT_WIDTH = 32
) ();

  logic                 i_ex_stall;
  logic                 i_ex_branch_taken;
  logic                 i_mem_busy;
  logic                 o_if_enable;
  logic                 o_id_enable;
  logic                 o_ex_enable;
  logic                 o_mem_enable;
  logic                 o_if_id_flush;
  logic                 o_id_ex_flush;
  logic                 o_ex_mem_flush;
  logic [1:0]           o_ctrl_state;
  logic [CNT_WIDTH-1:0] o_stall_count;
  logic [CNT_WIDTH-1:0] o_flush_count;

  modport master (
    input  i_ex_stall, i_ex_branch_taken, i_mem_busy,
    output o_if_enable, o_id_enable, o_ex_enable, o_mem_enable,
    output o_if_id_flush, o_id_ex_flush, o_ex_mem_flush,
    output o_ctrl_state, o_stall_count, o_flush_count
  );

  modport slave (
    output i_ex_stall, i_ex_branch_taken, i_mem_busy,
    input  o_if_enable, o_id_enable, o_ex_enable, o_mem_enable,
    input  o_if_id_flush, o_id_ex_flush, o_ex_mem_flush,
    input  o_ctrl_state, o_stall_count, o_flush_count
  );

endinterface

// File: rtl/pipeline_flow_controller.sv
// Stall/flush sequencer for the five-stage pipeline. Combinational stage enables and
// flushes are decoded from the FSM state, the redirect counter and the hazard inputs.
// Input priority is always MEM busy, then branch redirect, then load-use stall.
// Optional build macro: PIPELINE_PERF_CNT_EN adds saturating stall/flush cycle counters;
// without it the counter outputs are tied to zero.
module pipeline_flow_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input logic                        clk,
  input logic                        rst_n,
  pipeline_flow_controller_if.master bus
);

  typedef enum logic [1:0] {
    StRun        = 2'd0,
    StLoadBubble = 2'd1,
    StRedirect   = 2'd2,
    StMemWait    = 2'd3
  } state_e;

  localparam bit       MultiFlush = (FLUSH_CYCLES > 1);
  localparam logic [2:0] RcntLoad = 3'(FLUSH_CYCLES - 1);

  state_e     r_state, w_state_next;
  logic [2:0] r_rcnt, w_rcnt_next;
  logic [3:0] w_en;        // {IF, ID, EX, MEM}
  logic [2:0] w_flush;     // {IF_ID, ID_EX, EX_MEM}
  logic       w_decode_run;
  logic       w_stall_masked;

  // State and redirect counter; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_rcnt  <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_rcnt  <= w_rcnt_next;
    end
  end

  // Next-state and stage-control decode.
  always_comb begin
    w_en           = 4'b1111;
    w_flush        = 3'b000;
    w_state_next   = r_state;
    w_rcnt_next    = r_rcnt;
    w_decode_run   = 1'b0;
    w_stall_masked = 1'b0;

    unique case (r_state)
      StRun: w_decode_run = 1'b1;
      StLoadBubble: begin
        // The bubble has already been inserted; let the dependent instruction proceed.
        w_decode_run   = 1'b1;
        w_stall_masked = 1'b1;
      end
      StMemWait: begin
        if (bus.i_mem_busy) begin
          w_en = 4'b0000;
        end else begin
          w_decode_run = 1'b1;
        end
      end
      StRedirect: begin
        if (bus.i_mem_busy) begin
          // Freeze: no flush cycle is consumed while memory stalls.
          w_en = 4'b0000;
        end else begin
          w_flush[2] = 1'b1;
          if (bus.i_ex_branch_taken) begin
            w_flush[1]  = 1'b1;
            w_rcnt_next = RcntLoad;
          end else if (r_rcnt <= 3'd1) begin
            w_state_next = StRun;
            w_rcnt_next  = 3'd0;
          end else begin
            w_rcnt_next = r_rcnt - 3'd1;
          end
        end
      end
    endcase

    if (w_decode_run) begin
      if (bus.i_mem_busy) begin
        w_en         = 4'b0000;
        w_state_next = StMemWait;
      end else if (bus.i_ex_branch_taken) begin
        w_flush = 3'b110;
        if (MultiFlush) begin
          w_state_next = StRedirect;
          w_rcnt_next  = RcntLoad;
        end else begin
          w_state_next = StRun;
        end
      end else if (bus.i_ex_stall && !w_stall_masked) begin
        w_en         = 4'b0001;
        w_flush      = 3'b001;
        w_state_next = StLoadBubble;
      end else begin
        w_state_next = StRun;
      end
    end
  end

  // Reset forces every stage to hold a NOP, independent of the clock.
  always_comb begin
    bus.o_if_enable    = rst_n & w_en[3];
    bus.o_id_enable    = rst_n & w_en[2];
    bus.o_ex_enable    = rst_n & w_en[1];
    bus.o_mem_enable   = rst_n & w_en[0];
    bus.o_if_id_flush  = ~rst_n | w_flush[2];
    bus.o_id_ex_flush  = ~rst_n | w_flush[1];
    bus.o_ex_mem_flush = ~rst_n | w_flush[0];
    bus.o_ctrl_state   = r_state;
  end

`ifdef PIPELINE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_count, r_flush_count;
  logic                 w_any_stall;

  assign w_any_stall = ~&w_en;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_any_stall && (r_stall_count != {CNT_WIDTH{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
      if (w_flush[2] && (r_flush_count != {CNT_WIDTH{1'b1}})) begin
        r_flush_count <= r_flush_count + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.o_stall_count = r_stall_count;
  assign bus.o_flush_count = r_flush_count;
`else
  assign bus.o_stall_count = {CNT_WIDTH{1'b0}};
  assign bus.o_flush_count = {CNT_WIDTH{1'b0}};
`endif

endmodule
